// File: rtl/spi_slave_if.sv
// SPI pins plus the RAM-facing command/readback handshake of spi_slave_ctrl.
interface spi_slave_if #(
  parameter int MEM_WIDTH = 8
);
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [MEM_WIDTH+1:0] rx_data;
  logic                 rx_valid;
  logic [MEM_WIDTH-1:0] tx_data;
  logic                 tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave: MOSI frames -> 10-bit RAM command words, RAM read data -> MISO.
// Define SPI_SLAVE_SVA_EN to compile in protocol assertions.
module spi_slave_ctrl #(
  parameter int MEM_WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);
  localparam int RX_W  = MEM_WIDTH + 2;
  localparam int CNT_W = $clog2(RX_W + 1);
  localparam int TX_CW = $clog2(MEM_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RX_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RX_W);
  localparam logic [TX_CW-1:0] TX_LAST  = TX_CW'(MEM_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t               state_q, state_d;
  logic [RX_W-2:0]      shift_q, shift_d;
  logic [RX_W-1:0]      rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 rd_addr_seen_q, rd_addr_seen_d;
  logic [MEM_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [TX_CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 miso_q, miso_d;

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    bit_cnt_d      = bit_cnt_q;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;
    tx_busy_d      = tx_busy_q;
    tx_done_d      = tx_done_q;
    miso_d         = miso_q;

    if (state_q != IDLE && bus.SS_n) begin
      // Abort: drop the partial frame; a readback that already put out bit 0 counts as finished
      state_d   = IDLE;
      miso_d    = 1'b0;
      bit_cnt_d = '0;
      tx_busy_d = 1'b0;
      tx_done_d = 1'b0;
      if (tx_busy_q && tx_cnt_q == '0) rd_addr_seen_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d    = 1'b0;
          bit_cnt_d = '0;
          tx_busy_d = 1'b0;
          tx_done_d = 1'b0;
          if (!bus.SS_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          shift_d   = {shift_q[RX_W-3:0], bus.MOSI};
          bit_cnt_d = CNT_ONE;
          if (!bus.MOSI)          state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                    state_d = READ_ADD;
        end
        default: begin
          if (bit_cnt_q < CNT_FULL) begin
            shift_d   = {shift_q[RX_W-3:0], bus.MOSI};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_LAST) begin
              rx_data_d  = {shift_q, bus.MOSI};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
            end
          end else if (state_q == READ_DATA) begin
            if (tx_busy_q) begin
              if (tx_cnt_q != '0) begin
                miso_d     = tx_shift_q[MEM_WIDTH-1];
                tx_shift_d = {tx_shift_q[MEM_WIDTH-2:0], 1'b0};
                tx_cnt_d   = tx_cnt_q - 1'b1;
              end else begin
                miso_d         = 1'b0;
                tx_busy_d      = 1'b0;
                tx_done_d      = 1'b1;
                rd_addr_seen_d = 1'b0;
              end
            end else if (!tx_done_q && bus.tx_valid) begin
              miso_d     = bus.tx_data[MEM_WIDTH-1];
              tx_shift_d = {bus.tx_data[MEM_WIDTH-2:0], 1'b0};
              tx_cnt_d   = TX_LAST;
              tx_busy_d  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      bit_cnt_q      <= '0;
      rd_addr_seen_q <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      tx_busy_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      bit_cnt_q      <= bit_cnt_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_busy_q      <= tx_busy_d;
      tx_done_q      <= tx_done_d;
      miso_q         <= miso_d;
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.MISO     = miso_q;

`ifdef SPI_SLAVE_SVA_EN
  a_rx_valid_single: assert property (@(posedge clk) disable iff (rst)
    rx_valid_q |=> !rx_valid_q);
  a_rx_valid_full_frame: assert property (@(posedge clk) disable iff (rst)
    rx_valid_q |-> ($past(bit_cnt_q) == CNT_LAST && !$past(bus.SS_n)));
  a_miso_idle_low: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> !miso_q);
  a_read_data_entry: assert property (@(posedge clk) disable iff (rst)
    (state_q == READ_DATA && $past(state_q) != READ_DATA) |-> $past(rd_addr_seen_q));
`else
  // Assertions not compiled in this build.
`endif
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: stimulus queues expected words/bits, a monitor checks them.
module tb_spi_slave_ctrl;
  typedef struct {
    logic [9:0] data;
    int         cyc;
  } rx_exp_t;

  typedef struct {
    logic bit_v;
    int   cyc;
  } miso_exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  rx_exp_t   rx_q[$];
  miso_exp_t miso_q[$];

  spi_slave_if #(.MEM_WIDTH(8)) bus ();

  spi_slave_ctrl #(.MEM_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sole owner of the counters.
  always @(negedge clk) begin
    rx_exp_t   re;
    miso_exp_t me;
    if (rst) begin
      checks++;
      if (bus.rx_valid !== 1'b0 || bus.MISO !== 1'b0 || bus.rx_data !== 10'h000) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got rx_valid=%b MISO=%b rx_data=%h want 0/0/000",
                 cyc, bus.rx_valid, bus.MISO, bus.rx_data);
      end
    end else begin
      while (rx_q.size() > 0 && rx_q[0].cyc < cyc) begin
        re = rx_q.pop_front();
        checks++;
        failures++;
        $display("FAIL rx_missing got no rx_valid want rx_data=%h at cyc %0d", re.data, re.cyc);
      end
      if (bus.rx_valid) begin
        checks++;
        if (rx_q.size() == 0) begin
          failures++;
          $display("FAIL rx_unexpected cyc=%0d got rx_valid=1 rx_data=%h want no rx_valid", cyc, bus.rx_data);
        end else begin
          re = rx_q.pop_front();
          if (re.cyc != cyc || bus.rx_data !== re.data) begin
            failures++;
            $display("FAIL rx_word got rx_data=%h at cyc %0d want %h at cyc %0d",
                     bus.rx_data, cyc, re.data, re.cyc);
          end
        end
      end
      while (miso_q.size() > 0 && miso_q[0].cyc < cyc) begin
        me = miso_q.pop_front();
        checks++;
        failures++;
        $display("FAIL miso_skipped expected bit for cyc %0d never checked", me.cyc);
      end
      checks++;
      if (miso_q.size() > 0 && miso_q[0].cyc == cyc) begin
        me = miso_q.pop_front();
        if (bus.MISO !== me.bit_v) begin
          failures++;
          $display("FAIL miso_bit cyc=%0d got %b want %b", cyc, bus.MISO, me.bit_v);
        end
      end else if (bus.MISO !== 1'b0) begin
        failures++;
        $display("FAIL miso_idle cyc=%0d got %b want 0", cyc, bus.MISO);
      end
    end
    if (done) begin
      checks++;
      if (rx_q.size() != 0 || miso_q.size() != 0) begin
        failures++;
        $display("FAIL drain got rx_left=%0d miso_left=%0d want 0/0", rx_q.size(), miso_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // Lowers SS_n and samples nbits of w MSB-first; returns 2 time units after the last sampling edge.
  task automatic shift_frame(input logic [9:0] w, input int nbits);
    bus.SS_n = 1'b0;
    @(posedge clk); #2;
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = w[9-i];
      @(posedge clk); #2;
    end
  endtask

  task automatic end_frame();
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
  endtask

  task automatic full_frame(input logic [9:0] w);
    rx_q.push_back(rx_exp_t'{w, cyc + 11});
    shift_frame(w, 10);
  endtask

  // Complete frame, then offer tx_data one cycle after rx_valid.
  task automatic read_frame(input logic [9:0] w, input logic [7:0] d, input bit expect_miso);
    int m;
    full_frame(w);
    @(posedge clk); #2;
    m = cyc;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    if (expect_miso) begin
      for (int j = 0; j < 8; j++) miso_q.push_back(miso_exp_t'{d[7-j], m + 1 + j});
      miso_q.push_back(miso_exp_t'{1'b0, m + 9});
    end
    @(posedge clk); #2;
    bus.tx_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #2;
    end
    end_frame();
  endtask

  initial begin
    rst          = 1'b1;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;

    full_frame(10'h005);
    end_frame();

    // Asynchronous reset partway through a WRITE frame.
    shift_frame(10'h0F0, 5);
    rst = 1'b1;
    @(posedge clk); #2;
    rst      = 1'b0;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    @(posedge clk); #2;

    full_frame(10'h1AA);
    for (int i = 0; i < 3; i++) begin
      bus.MOSI = i[0];
      @(posedge clk); #2;
    end
    end_frame();

    read_frame(10'h205, 8'h00, 1'b0);
    read_frame(10'h3C3, 8'hAA, 1'b1);

    // Aborted READ_ADD must not flag an address.
    shift_frame(10'h2F0, 6);
    end_frame();
    read_frame(10'h203, 8'hFF, 1'b0);

    // Aborted frame with an address pending must keep it.
    shift_frame(10'h3FF, 4);
    end_frame();
    read_frame(10'h300, 8'h3C, 1'b1);

    repeat (3) begin
      @(posedge clk); #2;
    end
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
